// File: rtl/sha2_pkg.sv
// sha2_pkg: shared definitions for the SHA-2 message-schedule expander.
//   - state_t     : schedule FSM states {IDLE, RUN}
//   - IDX_W       : width of the round index (covers 0..79)
//   - s0_*/s1_*   : small-sigma rotate/shift amounts for a given word width
//                   (32 = SHA-224/256, 64 = SHA-384/512)
package sha2_pkg;

    localparam int IDX_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int s0_r1(input int w); return (w == 64) ?  1 :  7; endfunction
    function automatic int s0_r2(input int w); return (w == 64) ?  8 : 18; endfunction
    function automatic int s0_sh(input int w); return (w == 64) ?  7 :  3; endfunction
    function automatic int s1_r1(input int w); return (w == 64) ? 19 : 17; endfunction
    function automatic int s1_r2(input int w); return (w == 64) ? 61 : 19; endfunction
    function automatic int s1_sh(input int w); return (w == 64) ?  6 : 10; endfunction

endpackage

// File: rtl/sha2_small_sigma.sv
// sha2_small_sigma: combinational SHA-2 small sigma, y = rotr(x,R1) ^ rotr(x,R2) ^ (x >> SH).
//   WORD_W : 32 or 64
//   SEL    : 0 selects sigma0 constants, 1 selects sigma1 constants
// Ports:
//   x : input word
//   y : sigma result
module sha2_small_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SEL    = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam int R1 = (SEL == 1) ? s1_r1(WORD_W) : s0_r1(WORD_W);
    localparam int R2 = (SEL == 1) ? s1_r2(WORD_W) : s0_r2(WORD_W);
    localparam int SH = (SEL == 1) ? s1_sh(WORD_W) : s0_sh(WORD_W);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int r);
        return (v >> r) | (v << (WORD_W - r));
    endfunction

    assign y = rotr(x, R1) ^ rotr(x, R2) ^ (x >> SH);

endmodule

// File: rtl/sha2_msg_schedule.sv
// sha2_msg_schedule: SHA-2 message-schedule expander with a 16-word shifting window.
// Takes one 16-word block per blk handshake and streams W[0..ROUNDS-1], one word
// per w handshake. Window invariant: win[i] == W[t+i].
// Parameters:
//   WORD_W : 32 (ROUNDS=64) or 64 (ROUNDS=80)
//   ROUNDS : schedule length
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   blk_valid/blk_ready      : block handshake, blk_data word 0 in the MSBs
//   w_valid/w_ready          : schedule word handshake
//   w_data, w_idx, w_last    : W[t], t, (t == ROUNDS-1)
//   abort                    : only with SHA2_SCHED_ABORT_EN; drops the running block
module sha2_msg_schedule
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [16*WORD_W-1:0] blk_data,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_W-1:0]    w_data,
    output logic [IDX_W-1:0]     w_idx,
    output logic                 w_last
`ifdef SHA2_SCHED_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
        $error("sha2_msg_schedule: unsupported WORD_W/ROUNDS combination");
    end

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        t;
    logic [15:0][WORD_W-1:0] win;
    logic [WORD_W-1:0]       sig0, sig1, win_new;
    logic                    abort_hit;

`ifdef SHA2_SCHED_ABORT_EN
    assign abort_hit = (state == RUN) && abort;
`else
    assign abort_hit = 1'b0;
`endif

    sha2_small_sigma #(.WORD_W(WORD_W), .SEL(0)) u_s0 (.x(win[1]),  .y(sig0));
    sha2_small_sigma #(.WORD_W(WORD_W), .SEL(1)) u_s1 (.x(win[14]), .y(sig1));

    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
    assign win_new = sig1 + win[9] + sig0 + win[0];

    assign blk_ready = (state == IDLE);
    assign w_valid   = (state == RUN);
    assign w_data    = (state == RUN) ? win[0] : '0;
    assign w_idx     = t;
    assign w_last    = (state == RUN) && (t == IDX_W'(ROUNDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (blk_valid) state_nxt = RUN;
            // last word leaves via IDLE, so the next block waits one cycle
            RUN:     if (abort_hit || (w_ready && w_last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t   <= '0;
            win <= '0;
        end else if (state == IDLE) begin
            if (blk_valid) begin
                for (int i = 0; i < 16; i++)
                    win[i] <= blk_data[(15-i)*WORD_W +: WORD_W];
                t <= '0;
            end
        end else if (abort_hit) begin
            t <= '0;
        end else if (w_ready) begin
            if (w_last) begin
                t <= '0;
            end else begin
                win <= {win_new, win[15:1]};
                t   <= t + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Bench for sha2_msg_schedule: a 32-bit and a 64-bit instance share the stimulus;
// sel64 picks which one is driven and observed. Expected words come from the
// plain SHA-2 recurrence over a W[] array.
module tb_sha2_msg_schedule;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic blk_valid = 1'b0;
    logic w_ready = 1'b0;
    logic sel64 = 1'b0;
`ifdef SHA2_SCHED_ABORT_EN
    logic abort = 1'b0;
`endif

    logic [63:0]   blk_words [16];
    logic [511:0]  bd32;
    logic [1023:0] bd64;

    logic        br32, wv32, wl32;
    logic [31:0] wd32;
    logic [6:0]  wi32;
    logic        br64, wv64, wl64;
    logic [63:0] wd64;
    logic [6:0]  wi64;

    logic        cblk_ready, cw_valid, cw_last;
    logic [63:0] cw_data;
    logic [6:0]  cw_idx;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_w [80];
    logic [63:0] got_w [80];
    logic [63:0] ref_w [80];

    always #5 clk = ~clk;

    always_comb begin
        bd32 = '0;
        bd64 = '0;
        for (int i = 0; i < 16; i++) begin
            bd32[(15-i)*32 +: 32] = blk_words[i][31:0];
            bd64[(15-i)*64 +: 64] = blk_words[i];
        end
    end

    assign cblk_ready = sel64 ? br64 : br32;
    assign cw_valid   = sel64 ? wv64 : wv32;
    assign cw_last    = sel64 ? wl64 : wl32;
    assign cw_data    = sel64 ? wd64 : {32'h0, wd32};
    assign cw_idx     = sel64 ? wi64 : wi32;

    sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64)) d32 (
        .clk(clk), .rst(rst),
        .blk_valid(blk_valid & ~sel64), .blk_ready(br32), .blk_data(bd32),
        .w_valid(wv32), .w_ready(w_ready & ~sel64),
        .w_data(wd32), .w_idx(wi32), .w_last(wl32)
`ifdef SHA2_SCHED_ABORT_EN
        , .abort(abort & ~sel64)
`endif
    );

    sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80)) d64 (
        .clk(clk), .rst(rst),
        .blk_valid(blk_valid & sel64), .blk_ready(br64), .blk_data(bd64),
        .w_valid(wv64), .w_ready(w_ready & sel64),
        .w_data(wd64), .w_idx(wi64), .w_last(wl64)
`ifdef SHA2_SCHED_ABORT_EN
        , .abort(abort & sel64)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input bit w64);
        if (w64) return (x >> r) | (x << (64 - r));
        return ((x >> r) | (x << (32 - r))) & 64'hFFFF_FFFF;
    endfunction

    function automatic logic [63:0] sg0(input logic [63:0] x, input bit w64);
        if (w64) return rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7);
        return rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] sg1(input logic [63:0] x, input bit w64);
        if (w64) return rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6);
        return rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ (x >> 10);
    endfunction

    task automatic compute_model(input logic [63:0] b [16], input bit w64);
        logic [63:0] mask;
        int rounds;
        mask   = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        rounds = w64 ? 80 : 64;
        for (int i = 0; i < 16; i++) exp_w[i] = b[i] & mask;
        for (int i = 16; i < rounds; i++)
            exp_w[i] = (sg1(exp_w[i-2], w64) + exp_w[i-7] + sg0(exp_w[i-15], w64) + exp_w[i-16]) & mask;
    endtask

    task automatic rand_block(output logic [63:0] b [16]);
        for (int i = 0; i < 16; i++) b[i] = {$urandom, $urandom};
    endtask

    // Called at a negedge; offers b, streams the schedule and checks every word.
    // hold keeps blk_valid high with nb on the data bus once b is accepted.
    task automatic run_block(input logic [63:0] b [16], input logic [63:0] nb [16],
                             input bit hold, input bit rnd, input int stop_at,
                             output int waits);
        int rounds, k;
        bit stalled, wr;
        logic [63:0] hd;
        logic [6:0]  hi;
        logic        hl;
        rounds = sel64 ? 80 : 64;
        compute_model(b, sel64);
        blk_words = b;
        blk_valid = 1'b1;
        waits = 0;
        while (cblk_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: blk_ready=%b, required 1", cblk_ready);
            blk_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold) blk_words = nb;
        else      blk_valid = 1'b0;
        k = 0; stalled = 0;
        hd = '0; hi = '0; hl = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (k == stop_at) begin
                w_ready = 1'b0;
                return;
            end
            vectors++;
            if (cw_valid !== 1'b1 || cblk_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL run_flags k=%0d: w_valid=%b blk_ready=%b, required 1/0", k, cw_valid, cblk_ready);
            end
            if (stalled) begin
                vectors++;
                if (cw_data !== hd || cw_idx !== hi || cw_last !== hl) begin
                    miscompares++;
                    $display("FAIL stall_hold k=%0d: data=%h idx=%0d last=%b, required %h %0d %b",
                             k, cw_data, cw_idx, cw_last, hd, hi, hl);
                end
            end
            wr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            w_ready = wr;
            if (wr) begin
                vectors++;
                got_w[k] = cw_data;
                if (cw_data !== exp_w[k] || cw_idx !== k[6:0] || cw_last !== (k == rounds - 1)) begin
                    miscompares++;
                    $display("FAIL word k=%0d: data=%h idx=%0d last=%b, required %h %0d %b",
                             k, cw_data, cw_idx, cw_last, exp_w[k], k, (k == rounds - 1));
                end
                k++;
                stalled = 0;
            end else begin
                stalled = 1;
                hd = cw_data; hi = cw_idx; hl = cw_last;
            end
            @(negedge clk);
            if (wr && k == rounds) break;
        end
        w_ready = 1'b0;
        if (k != rounds) begin
            vectors++; miscompares++;
            $display("FAIL stream_len: words=%0d, required %0d", k, rounds);
        end
        vectors++;
        if (cblk_ready !== 1'b1 || cw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL end_idle: blk_ready=%b w_valid=%b, required 1/0", cblk_ready, cw_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        vectors++;
        if (br32 !== 1'b1 || wv32 !== 1'b0 || wl32 !== 1'b0 || wi32 !== 7'd0 || wd32 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset32: rdy=%b vld=%b last=%b idx=%0d data=%h, required 1 0 0 0 0",
                     br32, wv32, wl32, wi32, wd32);
        end
        vectors++;
        if (br64 !== 1'b1 || wv64 !== 1'b0 || wl64 !== 1'b0 || wi64 !== 7'd0 || wd64 !== 64'h0) begin
            miscompares++;
            $display("FAIL reset64: rdy=%b vld=%b last=%b idx=%0d data=%h, required 1 0 0 0 0",
                     br64, wv64, wl64, wi64, wd64);
        end
    endtask

    task automatic abc32_block(output logic [63:0] b [16]);
        for (int i = 0; i < 16; i++) b[i] = '0;
        b[0]  = 64'h6162_6380;
        b[15] = 64'h18;
    endtask

    task automatic test_abc32();
        logic [63:0] b [16];
        int w;
        sel64 = 1'b0;
        abc32_block(b);
        run_block(b, b, 0, 0, -1, w);
        vectors++;
        if (got_w[16] !== 64'h6162_6380) begin
            miscompares++; $display("FAIL abc32_w16: %h, required 61626380", got_w[16]);
        end
        vectors++;
        if (got_w[17] !== 64'h000F_0000) begin
            miscompares++; $display("FAIL abc32_w17: %h, required 000f0000", got_w[17]);
        end
        vectors++;
        if (got_w[18] !== 64'h7DA8_6405) begin
            miscompares++; $display("FAIL abc32_w18: %h, required 7da86405", got_w[18]);
        end
        ref_w = got_w;
    endtask

    task automatic test_backpressure();
        logic [63:0] b [16];
        int w;
        sel64 = 1'b0;
        abc32_block(b);
        run_block(b, b, 0, 1, -1, w);
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (got_w[i] !== ref_w[i]) begin
                miscompares++;
                $display("FAIL bp_vs_free i=%0d: %h, required %h", i, got_w[i], ref_w[i]);
            end
        end
    endtask

    task automatic test_random32();
        logic [63:0] b [16];
        int w;
        sel64 = 1'b0;
        for (int n = 0; n < 3; n++) begin
            rand_block(b);
            run_block(b, b, 0, 1, -1, w);
        end
    endtask

    task automatic test_abc64();
        logic [63:0] b [16];
        int w;
        sel64 = 1'b1;
        for (int i = 0; i < 16; i++) b[i] = '0;
        b[0]  = 64'h6162_6380_0000_0000;
        b[15] = 64'h18;
        run_block(b, b, 0, 0, -1, w);
        vectors++;
        if (got_w[16] !== 64'h6162_6380_0000_0000) begin
            miscompares++; $display("FAIL abc64_w16: %h, required 6162638000000000", got_w[16]);
        end
        rand_block(b);
        run_block(b, b, 0, 1, -1, w);
        sel64 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a [16];
        logic [63:0] b [16];
        int w1, w2;
        sel64 = 1'b0;
        rand_block(a);
        rand_block(b);
        run_block(a, b, 1, 1, -1, w1);
        run_block(b, b, 0, 0, -1, w2);
        vectors++;
        if (w2 !== 0) begin
            miscompares++;
            $display("FAIL b2b_gap: second block waited %0d extra cycles, required 0", w2);
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] b [16];
        int w;
        sel64 = 1'b0;
        rand_block(b);
        run_block(b, b, 0, 0, 30, w);
        vectors++;
        if (cw_idx !== 7'd30) begin
            miscompares++; $display("FAIL pre_reset_idx: %0d, required 30", cw_idx);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (cw_valid !== 1'b0 || cblk_ready !== 1'b1 || cw_idx !== 7'd0 || cw_data !== 64'h0 || cw_last !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: vld=%b rdy=%b idx=%0d data=%h last=%b, required 0 1 0 0 0",
                     cw_valid, cblk_ready, cw_idx, cw_data, cw_last);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_block(b);
        run_block(b, b, 0, 1, -1, w);
    endtask

`ifdef SHA2_SCHED_ABORT_EN
    task automatic test_abort();
        logic [63:0] b [16];
        logic [63:0] c [16];
        int w;
        sel64 = 1'b0;
        rand_block(b);
        run_block(b, b, 0, 0, 20, w);
        abort = 1'b1;
        w_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        w_ready = 1'b0;
        vectors++;
        if (cw_valid !== 1'b0 || cw_idx !== 7'd0 || cblk_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_run: vld=%b idx=%0d rdy=%b, required 0 0 1", cw_valid, cw_idx, cblk_ready);
        end
        // abort while idle must not block a simultaneous block handshake
        rand_block(c);
        compute_model(c, 1'b0);
        blk_words = c;
        blk_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        blk_valid = 1'b0;
        vectors++;
        if (cw_valid !== 1'b1 || cw_idx !== 7'd0 || cw_data !== exp_w[0]) begin
            miscompares++;
            $display("FAIL abort_idle: vld=%b idx=%0d data=%h, required 1 0 %h", cw_valid, cw_idx, cw_data, exp_w[0]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        run_block(c, c, 0, 1, -1, w);
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) blk_words[i] = '0;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_abc32();
        test_backpressure();
        test_random32();
        test_abc64();
        test_back_to_back();
        test_mid_reset();
`ifdef SHA2_SCHED_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha2_msg_schedule.md
Name: sha2_msg_schedule

Overview:
Parametrised SHA-2 message-schedule expander, generalising the fixed 32-bit sigma0/sigma1 functions to SHA-224/256 (32-bit) and SHA-384/512 (64-bit) word widths.
- Accepts one 16-word message block per handshake.
- Streams W[0..ROUNDS-1], one word per handshake, to the compression round engine.
- Uses a 16-entry shifting window, so no 64/80-word RAM is needed.

Parameters:
WORD_W, 32, word width; legal values 32 (SHA-256 family) and 64 (SHA-512 family); any other value is an elaboration error.
ROUNDS, 64, schedule length; 64 when WORD_W=32, 80 when WORD_W=64; any other value is an elaboration error.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
blk_valid  in  1  message block offered
blk_ready  out  1  block accepted when blk_valid & blk_ready
blk_data  in  16*WORD_W  block; word 0 occupies the MSBs, word 15 the LSBs
w_valid  out  1  schedule word available
w_ready  in  1  consumer takes the word when w_valid & w_ready
w_data  out  WORD_W  schedule word W[t]
w_idx  out  7  round index t
w_last  out  1  high with W[ROUNDS-1]
abort  in  1  present only with SHA2_SCHED_ABORT_EN

Behaviour:
- Reset: asynchronous, active-high; rst is the only reset. While rst is high:
  - state=IDLE, t=0, window cleared to 0;
  - w_valid=0, w_last=0, w_idx=0, w_data=0, blk_ready=1.
- States:
  - IDLE: blk_ready=1, w_valid=0.
  - RUN: blk_ready=0, w_valid=1.
- IDLE->RUN on a block handshake: win[i] <= blk word i, t <= 0.
  - Latency: W[0] appears on w_data the cycle after the block handshake.
- RUN outputs: w_data=win[0], w_idx=t, w_last=(t==ROUNDS-1).
- RUN, on a word handshake:
  - win[i] <= win[i+1] for i=0..14;
  - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], sum mod 2^WORD_W;
  - t <= t+1.
- Window invariant: win holds W[t..t+15], so words 0..15 pass through unmodified.
- Small-sigma constants:
  - WORD_W=32: s0 = rotr7 ^ rotr18 ^ shr3; s1 = rotr17 ^ rotr19 ^ shr10.
  - WORD_W=64: s0 = rotr1 ^ rotr8 ^ shr7; s1 = rotr19 ^ rotr61 ^ shr6.
- Word handshake with w_last=1: RUN->IDLE, t <= 0, window contents don't-care.
  - blk_ready rises the following cycle; no block is accepted in the same cycle as the last word (one-cycle bubble is required).
- Backpressure: while w_valid & !w_ready, w_data, w_idx and w_last hold stable and the window does not shift.
- blk_valid while in RUN is ignored; the block stays pending until IDLE.
- Reset asserted mid-block: the stream is discarded; after release the block sits in IDLE and is ready again.

Optional Feature:
Macro SHA2_SCHED_ABORT_EN.
- Defined: the abort port exists.
  - abort=1 in RUN returns to IDLE on the next edge: w_valid=0, t=0, any concurrent word handshake is discarded.
  - abort in IDLE has no effect and does not block a simultaneous block handshake.
- Undefined: the abort port is absent; a block always runs to completion.

Decomposition:
- Package sha2_pkg holds:
  - rotation/shift constants per width: S0_R1/S0_R2/S0_SH and S1_R1/S1_R2/S1_SH, as functions of WORD_W;
  - state enum {IDLE, RUN};
  - IDX_W=7.
- Sub-module sha2_small_sigma (params WORD_W, SEL 0/1): purely combinational rotr^rotr^shr. It is instantiated twice in the window update.

Test Plan:
- WORD_W=32, "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1:
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405;
  - w_last only at w_idx=63;
  - blk_ready returns 1 cycle after the last word.
- Same block with w_ready toggled pseudo-randomly: the word sequence is identical to the w_ready=1 run; w_data/w_idx are stable during every stall.
- WORD_W=64, ROUNDS=80, "abc" SHA-512 block (W0=0x6162638000000000, W15=0x18):
  - W16=0x6162638000000000;
  - 80 words emitted; w_last at idx 79.
- blk_valid held high continuously over 2 blocks:
  - second block accepted exactly 1 cycle after the first block's last word;
  - no overlap; blk_ready=0 throughout RUN.
- rst pulsed at w_idx=30 (asynchronous, mid-cycle):
  - outputs go to reset values immediately;
  - after release, the next block yields a correct W[0].
- With SHA2_SCHED_ABORT_EN, abort at w_idx=20:
  - w_valid=0 next cycle;
  - new block accepted; W[0] of the new block emitted with w_idx=0.
